// File: rtl/ball_pkg.sv
// Shared constants and types for the ball locator: RGB565 field positions,
// default colour thresholds, coordinate width and the result FSM encoding.
package ball_pkg;

    localparam int COORD_W = 10;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [4:0]  R_MIN_DEF   = 5'd20;
    localparam logic [5:0]  G_MAX_DEF   = 6'd30;
    localparam logic [4:0]  B_MAX_DEF   = 5'd10;
    localparam logic [15:0] MIN_PIX_DEF = 16'd8;
    localparam int          CNT_W_DEF   = 16;
    localparam int          SUM_W_DEF   = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } ball_state_t;

endpackage

// File: rtl/ball_locator_divider.sv
// Restoring unsigned divider, one quotient bit per cycle after a load cycle.
// done rises W cycles after start and stays high until the next start.
module seq_divider #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  den;
    logic [KW-1:0] k;
    logic          busy;
    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          fits;
    logic          unused_diff_msb;

    // The quotient register starts as the dividend and shifts its bits into the remainder.
    always_comb begin
        trial = {rem, quotient[W-1]};
        diff  = trial - {1'b0, den};
        fits  = (trial >= {1'b0, den});
    end

    assign unused_diff_msb = diff[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient <= '0;
            den      <= '0;
            rem      <= '0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            quotient <= dividend;
            den      <= divisor;
            rem      <= '0;
            k        <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            rem      <= fits ? diff[W-1:0] : trial[W-1:0];
            quotient <= {quotient[W-2:0], fits};
            k        <= k + 1'b1;
            if (k == K_LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_locator.sv
// Colour-threshold ball locator: per-frame hit count and centroid of RGB565 pixels.
// Optional bounding-box tracking is built when BALL_BBOX_EN is defined.
module ball_locator
    import ball_pkg::*;
#(
    parameter logic [4:0]  R_MIN   = R_MIN_DEF,
    parameter logic [5:0]  G_MAX   = G_MAX_DEF,
    parameter logic [4:0]  B_MAX   = B_MAX_DEF,
    parameter logic [15:0] MIN_PIX = MIN_PIX_DEF,
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int          SUM_W   = SUM_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write,
    input  logic [15:0]        wrdata,
    input  logic [COORD_W-1:0] horiz_count,
    input  logic               acapture,
    input  logic               newframe,
    output logic               result_valid,
    output logic               ball_found,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [CNT_W-1:0]   pix_count,
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
    output logic               overrun,
    output ball_state_t        state_dbg
);

    logic acap_s1, acap_s2, acap_d;
    logic nf_s1, nf_s2, nf_d;
    logic nf_rise, acap_fall;
    logic [COORD_W-1:0] line_y;
    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;
    logic hit, cnt_full, cnt_found;
    logic [COORD_W-1:0] pix_x;
    logic [CNT_W-1:0] cnt, snap_cnt;
    logic [SUM_W-1:0] sum_x, sum_y, cnt_ext, quot_x, quot_y;
    logic snap_found, done_x, done_y;
    logic div_start, take_snap, load_out;
    ball_state_t state, state_next;
    logic unused_quot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {acap_s1, acap_s2, acap_d} <= '0;
            {nf_s1, nf_s2, nf_d}       <= '0;
        end else begin
            {acap_s1, acap_s2, acap_d} <= {acapture, acap_s1, acap_s2};
            {nf_s1, nf_s2, nf_d}       <= {newframe, nf_s1, nf_s2};
        end
    end

    assign nf_rise   = nf_s2 & ~nf_d;
    assign acap_fall = acap_d & ~acap_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            line_y <= '0;
        else if (nf_rise)
            line_y <= '0;
        else if (acap_fall && line_y != COORD_MAX)
            line_y <= line_y + 1'b1;
    end

    assign pix_r     = wrdata[R_HI:R_LO];
    assign pix_g     = wrdata[G_HI:G_LO];
    assign pix_b     = wrdata[B_HI:B_LO];
    assign hit       = write && (pix_r >= R_MIN) && (pix_g <= G_MAX) && (pix_b <= B_MAX);
    assign pix_x     = horiz_count - 1'b1;
    assign cnt_full  = &cnt;
    assign cnt_found = (cnt >= CNT_W'(MIN_PIX));
    assign cnt_ext   = SUM_W'(cnt);

    // A hit on the frame-boundary cycle seeds the new frame instead of being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else if (nf_rise) begin
            cnt   <= hit ? CNT_W'(1) : '0;
            sum_x <= hit ? SUM_W'(pix_x) : '0;
            sum_y <= hit ? SUM_W'(line_y) : '0;
        end else if (hit && !cnt_full) begin
            cnt   <= cnt + 1'b1;
            sum_x <= sum_x + SUM_W'(pix_x);
            sum_y <= sum_y + SUM_W'(line_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cnt   <= '0;
            snap_found <= 1'b0;
        end else if (take_snap) begin
            snap_cnt   <= cnt;
            snap_found <= cnt_found;
        end
    end

    // Dividers load straight from the live accumulators on the snapshot edge.
    seq_divider #(.W(SUM_W)) u_div_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_x),
        .divisor  (cnt_ext),
        .quotient (quot_x),
        .done     (done_x)
    );

    seq_divider #(.W(SUM_W)) u_div_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_y),
        .divisor  (cnt_ext),
        .quotient (quot_y),
        .done     (done_y)
    );

    assign unused_quot = ^{quot_x[SUM_W-1:COORD_W], quot_y[SUM_W-1:COORD_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (nf_rise) state_next = cnt_found ? ST_DIV : ST_DONE;
            ST_DIV:  if (done_x && done_y) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        take_snap = (state == ST_IDLE) && nf_rise;
        div_start = take_snap && cnt_found;
        load_out  = (state == ST_DONE);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            ball_found   <= 1'b0;
            ball_x       <= '0;
            ball_y       <= '0;
            pix_count    <= '0;
        end else begin
            result_valid <= load_out;
            overrun      <= nf_rise && (state != ST_IDLE);
            if (load_out) begin
                ball_found <= snap_found;
                ball_x     <= snap_found ? quot_x[COORD_W-1:0] : '0;
                ball_y     <= snap_found ? quot_y[COORD_W-1:0] : '0;
                pix_count  <= snap_cnt;
            end
        end
    end

`ifdef BALL_BBOX_EN
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin <= COORD_MAX;
            xmax <= '0;
            ymin <= COORD_MAX;
            ymax <= '0;
        end else if (nf_rise) begin
            xmin <= hit ? pix_x : COORD_MAX;
            xmax <= hit ? pix_x : '0;
            ymin <= hit ? line_y : COORD_MAX;
            ymax <= hit ? line_y : '0;
        end else if (hit && !cnt_full) begin
            if (pix_x < xmin)  xmin <= pix_x;
            if (pix_x > xmax)  xmax <= pix_x;
            if (line_y < ymin) ymin <= line_y;
            if (line_y > ymax) ymax <= line_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_xmin <= COORD_MAX;
            snap_xmax <= '0;
            snap_ymin <= COORD_MAX;
            snap_ymax <= '0;
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
        end else begin
            if (take_snap) begin
                snap_xmin <= xmin;
                snap_xmax <= xmax;
                snap_ymin <= ymin;
                snap_ymax <= ymax;
            end
            if (load_out) begin
                bbox_xmin <= snap_found ? snap_xmin : '0;
                bbox_xmax <= snap_found ? snap_xmax : '0;
                bbox_ymin <= snap_found ? snap_ymin : '0;
                bbox_ymax <= snap_found ? snap_ymax : '0;
            end
        end
    end
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_ball_locator.sv
// Bench for ball_locator: directed frames plus random frames checked against a
// frame-level reference model (hit counts, sums, integer centroid, latency).
module tb_ball_locator;
  import ball_pkg::*;

  localparam int SUM_W     = 26;
  localparam int MIN_PIX   = 8;
  localparam int LAT_FOUND = SUM_W + 2;
  localparam int EW        = 109;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write = 1'b0;
  logic [15:0] wrdata = '0;
  logic [9:0]  horiz_count = '0;
  logic        acapture = 1'b0;
  logic        newframe = 1'b0;
  logic        result_valid, ball_found, overrun;
  logic [9:0]  ball_x, ball_y, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic [15:0] pix_count;
  ball_state_t state_dbg;

  ball_locator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write        (write),
    .wrdata       (wrdata),
    .horiz_count  (horiz_count),
    .acapture     (acapture),
    .newframe     (newframe),
    .result_valid (result_valid),
    .ball_found   (ball_found),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .pix_count    (pix_count),
    .bbox_xmin    (bbox_xmin),
    .bbox_xmax    (bbox_xmax),
    .bbox_ymin    (bbox_ymin),
    .bbox_ymax    (bbox_ymax),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  int ovr_seen = 0;
  int exp_ovr = 0;
  int last_found, last_x, last_y, last_cnt, last_bx0, last_bx1, last_by0, last_by1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax, m_line, busy_end;

  function automatic bit is_hit(input logic [15:0] p);
    int r, g, b;
    r = int'(p) / 2048;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    return (r >= 20) && (g <= 30) && (b <= 10);
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
  endtask

  task automatic model_pixel(input logic [15:0] p, input int x);
    if (is_hit(p) && m_cnt < 65535) begin
      m_cnt++;
      m_sx += x;
      m_sy += m_line;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (m_line < m_ymin) m_ymin = m_line;
      if (m_line > m_ymax) m_ymax = m_line;
    end
  endtask

  // Frame end seen by the DUT on edge s: either a queued result or an overrun.
  task automatic model_frame_end(input int s);
    bit found;
    int ex, ey, due, b0, b1, b2, b3;
    found = (m_cnt >= MIN_PIX);
    if (s - 1 < busy_end) begin
      exp_ovr++;
    end else begin
      ex = found ? m_sx / m_cnt : 0;
      ey = found ? m_sy / m_cnt : 0;
      b0 = 0; b1 = 0; b2 = 0; b3 = 0;
`ifdef BALL_BBOX_EN
      if (found) begin
        b0 = m_xmin; b1 = m_xmax; b2 = m_ymin; b3 = m_ymax;
      end
`endif
      due = s + (found ? LAT_FOUND : 1);
      exp_q.push_back({32'(due), found, 10'(ex), 10'(ey), 16'(m_cnt),
                       10'(b0), 10'(b1), 10'(b2), 10'(b3)});
      busy_end = due;
    end
    model_clear();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency",   64'(cyc),   e[108:77]);
        check("found",     ball_found, e[76]);
        check("ball_x",    ball_x,     e[75:66]);
        check("ball_y",    ball_y,     e[65:56]);
        check("pix_count", pix_count,  e[55:40]);
        check("bbox_xmin", bbox_xmin,  e[39:30]);
        check("bbox_xmax", bbox_xmax,  e[29:20]);
        check("bbox_ymin", bbox_ymin,  e[19:10]);
        check("bbox_ymax", bbox_ymax,  e[9:0]);
      end
      last_found = int'(ball_found); last_x = int'(ball_x); last_y = int'(ball_y);
      last_cnt = int'(pix_count);
      last_bx0 = int'(bbox_xmin); last_bx1 = int'(bbox_xmax);
      last_by0 = int'(bbox_ymin); last_by1 = int'(bbox_ymax);
    end
    if (rst_n && overrun) ovr_seen++;
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_pixel(input logic [15:0] p, input int x);
    write = 1'b1;
    wrdata = p;
    horiz_count = 10'(x + 1);
    model_pixel(p, x);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic next_line();
    acapture = 1'b1;
    idle(2);
    acapture = 1'b0;
    idle(4);
    if (m_line < 1023) m_line++;
  endtask

  task automatic new_frame(input bit boundary_hit);
    int s;
    newframe = 1'b1;
    s = cyc + 3;
    model_frame_end(s);
    if (boundary_hit) begin
      idle(2);
      put_pixel(16'hF800, 300);
    end else begin
      idle(3);
    end
    newframe = 1'b0;
    m_line = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_found"}, ball_found, 0);
    check({tag, "_x"}, ball_x, 0);
    check({tag, "_y"}, ball_y, 0);
    check({tag, "_cnt"}, pix_count, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_bbox"}, {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  function automatic logic [15:0] rand_pixel();
    logic [31:0] rnd;
    case ($urandom_range(0, 2))
      0: return {5'($urandom_range(20, 31)), 6'($urandom_range(0, 30)), 5'($urandom_range(0, 10))};
      1: return {5'($urandom_range(19, 20)), 6'($urandom_range(30, 31)), 5'($urandom_range(10, 11))};
      default: begin
        rnd = $urandom();
        return rnd[15:0];
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    m_line = 0;
    busy_end = 0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Start from a clean frame (empty frame reports not found).
    new_frame(0);
    wait_done();
    check("empty_cnt", 64'(last_cnt), 0);

    // Single position: 8 red hits at x=100 on line 3.
    repeat (3) next_line();
    repeat (8) put_pixel(16'hF800, 100);
    new_frame(0);
    wait_done();
    check("single_x", 64'(last_x), 100);
    check("single_y", 64'(last_y), 3);
    check("single_cnt", 64'(last_cnt), 8);
    check("single_found", 64'(last_found), 1);

    // Centroid: x=10..19 on lines 2 and 4, green non-hits interleaved.
    repeat (2) next_line();
    for (int x = 10; x < 20; x++) begin
      put_pixel(16'hF800, x);
      put_pixel(16'h07E0, x + 100);
    end
    repeat (2) next_line();
    for (int x = 10; x < 20; x++) begin
      put_pixel(16'h07E0, x + 200);
      put_pixel(16'hF800, x);
    end
    new_frame(0);
    wait_done();
    check("centroid_x", 64'(last_x), 14);
    check("centroid_y", 64'(last_y), 3);
    check("centroid_cnt", 64'(last_cnt), 20);
    check("centroid_found", 64'(last_found), 1);

    // Below threshold: 5 hits.
    next_line();
    repeat (5) put_pixel(16'hF800, 33);
    new_frame(0);
    wait_done();
    check("below_found", 64'(last_found), 0);
    check("below_xy", 64'({last_x, last_y}), 0);
    check("below_cnt", 64'(last_cnt), 5);

    // Boundary write lands in the following frame.
    repeat (8) put_pixel(16'hF800, 200);
    new_frame(1);
    wait_done();
    check("boundary_cur_cnt", 64'(last_cnt), 8);
    repeat (8) put_pixel(16'hF800, 200);
    new_frame(0);
    wait_done();
    check("boundary_next_cnt", 64'(last_cnt), 9);

    // Overrun: second frame end 5 cycles after the first.
    repeat (8) put_pixel(16'hF800, 50);
    new_frame(0);
    idle(2);
    new_frame(0);
    wait_done();
    check("overrun_first_x", 64'(last_x), 50);
    check("overrun_first_cnt", 64'(last_cnt), 8);
    check("overrun_pulses", 64'(ovr_seen), 1);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(1, 6);
      for (int l = 0; l < nl; l++) begin
        int np;
        np = $urandom_range(0, 12);
        for (int p = 0; p < np; p++) begin
          put_pixel(rand_pixel(), $urandom_range(0, 639));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        if ($urandom_range(0, 4) != 0) next_line();
      end
      new_frame($urandom_range(0, 3) == 0);
      wait_done();
    end

    // Reset in the middle of a division.
    repeat (8) put_pixel(16'hF800, 400);
    new_frame(0);
    idle(8);
    check("pre_reset_state", state_dbg, ST_DIV);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_clear();
    m_line = 0;
    busy_end = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    idle(1);
    rst_n = 1'b1;
    idle(40);

    // Bounding box: hits at (5,1) and (60,7).
    next_line();
    repeat (4) put_pixel(16'hF800, 5);
    repeat (6) next_line();
    repeat (4) put_pixel(16'hF800, 60);
    new_frame(0);
    wait_done();
    check("bbox_frame_x", 64'(last_x), 32);
    check("bbox_frame_y", 64'(last_y), 4);
`ifdef BALL_BBOX_EN
    check("bbox_box", 64'({10'(last_bx0), 10'(last_bx1), 10'(last_by0), 10'(last_by1)}),
          64'({10'd5, 10'd60, 10'd1, 10'd7}));
`else
    check("bbox_box", 64'({10'(last_bx0), 10'(last_bx1), 10'(last_by0), 10'(last_by1)}), 0);
`endif

    wait_done();
    check("overrun_total", 64'(ovr_seen), 64'(exp_ovr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ball_locator.md
# ball_locator

Downstream of the pixel-copy and line-capture stages, this block consumes the RGB565 pixel stream and classifies each pixel against a colour threshold. Per frame it accumulates the hit count and the hit X and Y coordinate sums. At each frame boundary it divides these sums to produce the ball centroid. The result feeds the tracking/servo logic as a one-cycle `result_valid` pulse with held outputs.

## Interface
- `R_MIN`, 5'd20: minimum red component (inclusive) for a hit.
- `G_MAX`, 6'd30: maximum green component (inclusive).
- `B_MAX`, 5'd10: maximum blue component (inclusive).
- `MIN_PIX`, 16'd8: minimum hit count for `ball_found`.
- `CNT_W`, 16: hit counter width.
- `SUM_W`, 26: X/Y sum accumulator width.

Ports:
- `clk` in 1: system clock, the same clock the pixel-copy stage uses.
- `rst_n` in 1: asynchronous, active-low reset.
- `write` in 1: one-cycle pixel strobe from the pixel-copy stage.
- `wrdata` in 16: RGB565 pixel, valid while `write`=1.
- `horiz_count` in 10: pixel index, already incremented when `write` is asserted, so 1-based.
- `acapture` in 1: line-active level from the line-capture stage, asynchronous to `clk`.
- `newframe` in 1: frame-start level, asynchronous to `clk`.
- `result_valid` out 1: one-cycle pulse; result outputs are updated on this cycle.
- `ball_found` out 1: hit count was ≥ `MIN_PIX`.
- `ball_x` out 10: centroid X.
- `ball_y` out 10: centroid Y, in captured-line units.
- `pix_count` out CNT_W: frame hit count.
- `bbox_xmin`, `bbox_xmax`, `bbox_ymin`, `bbox_ymax` out 10 each: bounding box (see Configuration).
- `overrun` out 1: one-cycle pulse when a frame end is dropped.

## Operation
- **Synchronisers.** `acapture` and `newframe` each pass through 2-flop synchronisers. The block registers the synchronised values to detect edges.
- **Line counter.** `line_y` (10 b) resets to 0 on a synchronised `newframe` rise. It increments on each synchronised `acapture` fall and saturates at 1023.
- **Classification.** r=`wrdata[15:11]`, g=`[10:5]`, b=`[4:0]`. Hit = `write` & r≥`R_MIN` & g≤`G_MAX` & b≤`B_MAX`. Pixel x = `horiz_count`−1.
- **Accumulation on a hit.** `cnt`+=1, `sum_x`+=x, `sum_y`+=`line_y`.
- **Saturation.** If `cnt` is all-ones, further hits are ignored and all three accumulators freeze for the rest of the frame.
- **FSM states:** IDLE, DIV, DONE.
  - **IDLE.** On a synchronised `newframe` rise, snapshot `cnt`/`sum_x`/`sum_y`/bbox and clear the accumulators in the same cycle.
    - If the snapshot count is ≥ `MIN_PIX`, go to DIV.
    - Otherwise go to DONE with `found`=0 and x=y=0.
  - **DIV.** Two `seq_divider` instances run in parallel: `sum_x/cnt` and `sum_y/cnt`. Go to DONE when both assert `done`.
  - **DONE.** Load outputs, pulse `result_valid`, return to IDLE.
- **Frame end while busy.** A `newframe` rise in DIV or DONE still clears the accumulators. That frame's snapshot is discarded and `overrun` pulses.
- **Quotient width.** Quotients are truncated to 10 bits. The quotient is always ≤1023 because every x is ≤639 and every y is ≤1023.

## Timing
- **Reset values.** All outputs are 0. Accumulators, `line_y` and the synchronisers are 0. The FSM is in IDLE. Bbox min registers are 10'h3FF and max registers are 0.
- **Accumulator latency.** A hit on a `write` cycle is visible in the accumulators at the next edge.
- **Write on the snapshot cycle.** It belongs to the new frame: the accumulator is loaded with that pixel's contribution instead of 0.
- **Edge-detect latency.** A `newframe` rise reaches the snapshot cycle after 3 `clk` edges (2 synchroniser flops + edge register).
- **Result latency from snapshot:**
  - Found: `result_valid` asserts SUM_W+2 cycles after the snapshot (1 load cycle, SUM_W divide iterations, 1 DONE cycle).
  - Not found: `result_valid` asserts 1 cycle after the snapshot.
- **Output hold.** Outputs hold their values until the next `result_valid`.
- **Reset mid-division.** The divider aborts, the FSM returns to IDLE and no `result_valid` is issued.

## Configuration
- **`BALL_BBOX_EN` defined.** Per-frame min/max of hit x and `line_y` are tracked and snapshotted, and the bbox outputs load on `result_valid`. When the frame is not found, the outputs are 0.
- **`BALL_BBOX_EN` not defined.** No bbox registers are built and the bbox outputs are tied to 0.

## Structure
- **Shared package `ball_pkg`.**
  - RGB565 field slice constants.
  - FSM state encoding (IDLE/DIV/DONE).
  - Default threshold constants.
  - Coordinate width constant (10).
- **Sub-module `seq_divider`.** Parameter W. Restoring divider producing one quotient bit per cycle. Ports: `clk`, `rst_n`, `start`, `dividend`[W], `divisor`[W], `quotient`[W], `done`. A zero divisor is never issued.

## Test plan
- **Single hit.** Pixel 16'hF800 (red) with `horiz_count`=101 on line 3, then `newframe` → `result_valid` SUM_W+2 cycles after the snapshot, `ball_x`=100, `ball_y`=3, `pix_count`=1 (with `MIN_PIX`=1).
- **Centroid.** Hits at x=10..19 on lines 2 and 4, non-hit 16'h07E0 pixels interleaved → `ball_x`=14, `ball_y`=3, `pix_count`=20, `ball_found`=1.
- **Below threshold.** 5 hits with `MIN_PIX`=8 → `result_valid` 1 cycle after the snapshot, `ball_found`=0, `ball_x`=`ball_y`=0, `pix_count`=5.
- **Boundary write.** A `write` hit on the snapshot cycle → counted in the next frame (`pix_count` increases by 1 there), not in the current one.
- **Overrun.** Second `newframe` rise 5 cycles after the first → `overrun` pulses once, first result still reported correctly, second frame's data discarded.
- **Reset and bbox.** `rst_n` low mid-DIV → outputs 0 and no `result_valid`. With `BALL_BBOX_EN`, hits at (5,1) and (60,7) → bbox 5/60/1/7.
